pcm_fifo_wr_arbiter: RTL and testbench

- Shares one fifo_sync write port between NUM_CH PCM channel producers, e.g. decimator outputs for stereo or array PDM mics.
- Each channel gets a one-entry holding register. Pending samples are granted to the FIFO round-robin, and each written word is tagged with its channel ID.
- Producers cannot stall. A sample that arrives while its channel's holding register is still occupied is dropped and counted.
- Sits between the decimation filters and the PCM output FIFO.

---
 rtl/pcm_fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_pcm_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one PCM FIFO write port between channels.
// One holding register per channel; late samples are dropped and counted.
module pcm_fifo_wr_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic [NUM_CH-1:0]              ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_i,
  input  logic                           fifo_full_i,
  input  logic                           fifo_overflow_i,
  output logic                           fifo_wr_en_o,
  output logic [CH_W+DATA_WIDTH-1:0]     fifo_wr_data_o,
  output logic [NUM_CH-1:0]              pending_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]    drop_cnt_o,
  output logic                           ovf_sticky_o
);

  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     drop;
  logic [CH_W-1:0]       last_q, last_d;
  logic [CH_W-1:0]       cand;
  logic                  ovf_q, ovf_d;
  logic                  grant;

  // First pending channel after the last one granted, wrapping.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        cand  = CH_W'(idx);
      end
    end
  end

  assign grant = enable_i && (|pend_q) && !fifo_full_i;

  assign fifo_wr_en_o   = grant;
  assign fifo_wr_data_o = grant ? {cand, hold_q[cand]} : '0;

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    last_d = last_q;
    drop   = '0;
    if (!enable_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        hold_d[k] = '0;
      end
      pend_d = '0;
      last_d = CH_W'(NUM_CH - 1);
    end else begin
      if (grant) begin
        pend_d[cand] = 1'b0;
        last_d       = cand;
      end
      // A same-cycle grant frees the slot for the incoming sample.
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_valid_i[k]) begin
          if (!pend_q[k] || (grant && cand == CH_W'(k))) begin
            hold_d[k] = ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            pend_d[k] = 1'b1;
          end else begin
            drop[k] = 1'b1;
          end
        end
      end
    end
  end

  // New events take precedence over a coincident clear.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (drop[k]) begin
        if (clear_i) begin
          cnt_d[k] = CNT_WIDTH'(1);
        end else if (cnt_q[k] != '1) begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end else if (clear_i) begin
        cnt_d[k] = '0;
      end
    end
    ovf_d = fifo_overflow_i | (ovf_q & ~clear_i);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        hold_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      pend_q <= '0;
      last_q <= CH_W'(NUM_CH - 1);
      ovf_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        hold_q[k] <= hold_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      pend_q <= pend_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  always_comb begin
    drop_cnt_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      drop_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end
  end

  assign pending_o    = pend_q;
  assign ovf_sticky_o = ovf_q;

endmodule

// File: tb/tb_pcm_fifo_wr_arbiter.sv
// Scoreboard bench for pcm_fifo_wr_arbiter with two channels.
// Expected FIFO words are queued at stimulus time and popped on writes.
module tb_pcm_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, full, ovf;
  logic [1:0]  vld;
  logic [31:0] data;
  logic        wr_en;
  logic [16:0] wr_data;
  logic [1:0]  pend;
  logic [15:0] cnt;
  logic        sticky;

  int n_chk  = 0;
  int n_fail = 0;
  logic [16:0] sb_q [$];

  pcm_fifo_wr_arbiter dut (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .enable_i        (en),
    .clear_i         (clr),
    .ch_valid_i      (vld),
    .ch_data_i       (data),
    .fifo_full_i     (full),
    .fifo_overflow_i (ovf),
    .fifo_wr_en_o    (wr_en),
    .fifo_wr_data_o  (wr_data),
    .pending_o       (pend),
    .drop_cnt_o      (cnt),
    .ovf_sticky_o    (sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [15:0] d0,
                        input logic [15:0] d1);
    vld  = m;
    data = {d1, d0};
    tick();
    vld  = 2'b00;
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_wr", 64'(sb_q.size()), 64'd1);
      end else begin
        chk("sb_wr_data", 64'(wr_data), 64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    full  = 1'b0;
    ovf   = 1'b0;
    vld   = 2'b00;
    data  = '0;
    repeat (3) tick();
    chk("rst_pending", 64'(pend), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();

    // single sample, one-cycle latency
    sb_q.push_back(17'h11234);
    strobe(2'b10, 16'h0000, 16'h1234);
    @(negedge clk);
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_pending", 64'(pend), 64'd2);
    tick();
    chk("single_pend_clr", 64'(pend), 64'd0);

    // round robin across two bursts
    full = 1'b1;
    strobe(2'b11, 16'hAAAA, 16'hBBBB);
    chk("rr_pending", 64'(pend), 64'd3);
    chk("rr_full_no_wr", 64'(wr_en), 64'd0);
    sb_q.push_back(17'h0AAAA);
    sb_q.push_back(17'h1BBBB);
    full = 1'b0;
    repeat (3) tick();
    full = 1'b1;
    strobe(2'b11, 16'hCCCC, 16'hDDDD);
    sb_q.push_back(17'h0CCCC);
    sb_q.push_back(17'h1DDDD);
    full = 1'b0;
    repeat (3) tick();
    chk("rr_drained", 64'(pend), 64'd0);

    // drop and saturation
    full = 1'b1;
    strobe(2'b01, 16'h0001, 16'h0000);
    strobe(2'b01, 16'h0002, 16'h0000);
    chk("drop_cnt1", 64'(cnt[7:0]), 64'd1);
    chk("drop_pending", 64'(pend), 64'd1);
    sb_q.push_back(17'h00001);
    full = 1'b0;
    repeat (2) tick();
    full = 1'b1;
    sb_q.push_back(17'h05555);
    strobe(2'b01, 16'h5555, 16'h0000);
    vld  = 2'b01;
    data = {16'h0000, 16'h6666};
    repeat (300) tick();
    vld = 2'b00;
    chk("drop_sat", 64'(cnt[7:0]), 64'd255);
    chk("drop_ch1_zero", 64'(cnt[15:8]), 64'd0);
    full = 1'b0;
    repeat (2) tick();

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_cnt", 64'(cnt), 64'd0);

    // same-cycle consume and refill
    sb_q.push_back(17'h01111);
    sb_q.push_back(17'h02222);
    vld  = 2'b01;
    data = {16'h0000, 16'h1111};
    tick();
    data = {16'h0000, 16'h2222};
    tick();
    vld = 2'b00;
    tick();
    chk("refill_no_drop", 64'(cnt[7:0]), 64'd0);
    chk("refill_drained", 64'(pend), 64'd0);

    // disable with both pending
    full = 1'b1;
    strobe(2'b11, 16'h3333, 16'h4444);
    chk("dis_pending_pre", 64'(pend), 64'd3);
    en  = 1'b0;
    vld = 2'b11;
    #1;
    chk("dis_no_wr", 64'(wr_en), 64'd0);
    tick();
    vld = 2'b00;
    chk("dis_pending_clr", 64'(pend), 64'd0);
    chk("dis_cnt_hold", 64'(cnt), 64'd0);
    tick();
    en   = 1'b1;
    full = 1'b0;
    sb_q.push_back(17'h07777);
    sb_q.push_back(17'h18888);
    strobe(2'b11, 16'h7777, 16'h8888);
    repeat (3) tick();

    // clear coincident with drop and overflow
    full = 1'b1;
    sb_q.push_back(17'h10007);
    strobe(2'b10, 16'h0000, 16'h0007);
    vld  = 2'b10;
    data = {16'h0008, 16'h0000};
    clr  = 1'b1;
    ovf  = 1'b1;
    tick();
    vld = 2'b00;
    clr = 1'b0;
    ovf = 1'b0;
    chk("clr_drop_wins", 64'(cnt[15:8]), 64'd1);
    chk("clr_ovf_wins", 64'(sticky), 64'd1);
    tick();
    chk("sticky_holds", 64'(sticky), 64'd1);
    full = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sticky_clear", 64'(sticky), 64'd0);

    // async reset mid-burst
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    sb_q.push_back(17'h0EEEE);
    sb_q.push_back(17'h1FFFF);
    strobe(2'b11, 16'hEEEE, 16'hFFFF);
    tick();
    chk("mid_wr_active", 64'(wr_en), 64'd1);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_wr_data", 64'(wr_data), 64'd0);
    chk("arst_pending", 64'(pend), 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_sticky", 64'(sticky), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
